gcd_seq: RTL
============

GCD_SEQ -- requirements
Module: gcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: operand pair a/b is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-006 SHALL have port a, input, WIDTH bits: first unsigned operand.
REQ-007 SHALL have port b, input, WIDTH bits: second unsigned operand.
REQ-008 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port result, output, WIDTH bits: gcd(a,b).
REQ-011 SHALL have port iter_count, output, WIDTH bits: subtraction count (present only under GCD_ITER_COUNT_EN).

Function
REQ-012 SHALL implement a registered FSM with states IDLE, CALC and DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE, both decoded from state.
REQ-014 SHALL, in IDLE on an edge with in_valid=1, capture x<=a and y<=b, clear the subtraction count, and go to CALC; with in_valid=0 it SHALL stay in IDLE.
REQ-015 SHALL, in CALC each cycle: if x==0, y==0 or x==y, register result<=x|y and go to DONE; else if x>y, x<=x-y; else y<=y-x; count +1 per subtraction.
REQ-016 SHALL take latency from acceptance edge to first out_valid=1 of (subtractions+1) cycles, e.g. gcd(12,8) = 3 cycles.
REQ-017 SHALL return gcd(0,b)=b, gcd(a,0)=a and gcd(0,0)=0 after 1 CALC cycle.
REQ-018 SHALL hold result (and iter_count) stable while in DONE and out_ready=0.
REQ-019 SHALL, in DONE on an edge with out_ready=1, go to IDLE, so in_ready rises the next cycle; result SHALL keep its last value in IDLE.
REQ-020 SHALL ignore a, b and in_valid in CALC and DONE, with no queuing and no effect on the in-flight operation.
REQ-021 SHALL perform all arithmetic unsigned in WIDTH bits; subtraction never underflows by construction.

Reset
REQ-022 SHALL, while rst_n=0, force state=IDLE and x, y, result and count to 0, so in_ready=1 and out_valid=0.
REQ-023 SHALL abort any in-flight CALC or DONE on reset assertion, discard the operation, and emit no result.
REQ-024 SHALL allow acceptance on the first rising clk edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with macro GCD_ITER_COUNT_EN defined, provide port iter_count, driven from the WIDTH-bit subtraction counter and valid while out_valid=1.
REQ-026 SHALL, with GCD_ITER_COUNT_EN undefined, omit the iter_count port and counter logic; all other behaviour is identical.
REQ-027 SHALL need no counter saturation: the count is at most max(a,b)-1 < 2^WIDTH.

Verification
REQ-028 SHALL cover, WIDTH=32: accept a=12, b=8 -> out_valid 3 cycles after acceptance, result=4, iter_count=2.
REQ-029 SHALL cover: a=0, b=35 -> result=35 after 1 CALC cycle; a=0, b=0 -> result=0; a=17, b=17 -> result=17, iter_count=0.
REQ-030 SHALL cover: a=1, b=20 -> result=1, iter_count=19, out_valid 20 cycles after acceptance.
REQ-031 SHALL cover: a=48, b=18 with out_ready=0 for 5 cycles -> result=6 held stable, in_ready=0 throughout; out_ready=1 -> IDLE, in_ready=1 the next cycle.
REQ-032 SHALL cover: rst_n pulsed low mid-CALC of a=1000, b=3 -> out_valid=0 and result=0 immediately, in_ready=1; a new pair 21, 14 then yields 7.
REQ-033 SHALL cover: a and b toggled with in_valid=1 during CALC -> result unaffected; WIDTH=8, a=255, b=1 -> result=1, iter_count=254.

Source files
------------

// File: rtl/gcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gcd_seq : subtractive GCD engine, ready/valid in and out, one pair in    |
// | flight. Optional iter_count output enabled by macro GCD_ITER_COUNT_EN.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gcd_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
`ifdef GCD_ITER_COUNT_EN
   ,
   output logic [WIDTH-1:0] iter_count
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] result_q, result_d;
`ifdef GCD_ITER_COUNT_EN
   logic [WIDTH-1:0] count_q, count_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         result_q <= '0;
`ifdef GCD_ITER_COUNT_EN
         count_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         result_q <= result_d;
`ifdef GCD_ITER_COUNT_EN
         count_q  <= count_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      result_d = result_q;
`ifdef GCD_ITER_COUNT_EN
      count_d  = count_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d     = a;
               y_d     = b;
`ifdef GCD_ITER_COUNT_EN
               count_d = '0;
`endif
               state_d = CALC;
            end
         end
         CALC: begin
            // A zero operand or equal operands means the other (or either) is the gcd.
            if ((x_q == '0) || (y_q == '0) || (x_q == y_q)) begin
               result_d = x_q | y_q;
               state_d  = DONE;
            end else begin
               if (x_q > y_q) begin
                  x_d = x_q - y_q;
               end else begin
                  y_d = y_q - x_q;
               end
`ifdef GCD_ITER_COUNT_EN
               count_d = count_q + WIDTH'(1);
`endif
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
`ifdef GCD_ITER_COUNT_EN
   assign iter_count = count_q;
`endif

endmodule
`default_nettype wire
